// File: rtl/cdb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : cdb_arbiter
// Brief   : One-deep result buffer per functional unit with round-robin grant
//           onto the common data bus; back-pressure and squash flush.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
    parameter int FU_NUM = 4,
    parameter int SEL_W  = $clog2(FU_NUM)
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   flush,
    input  logic [FU_NUM-1:0]                      fu_valid,
    input  logic [FU_NUM-1:0][`XLEN-1:0]           fu_value,
    input  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]    fu_rob_tag,
    output logic [FU_NUM-1:0]                      fu_ready,
    output logic [FU_NUM-1:0][`XLEN-1:0]           cdb_values,
    output logic                                   select_flag,
    output logic [SEL_W-1:0]                       select_signal,
    output logic [`ROB_TAG_LEN-1:0]                ROB_tag
);

    logic [FU_NUM-1:0]                   r_full;
    logic [FU_NUM-1:0][`XLEN-1:0]        r_value;
    logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] r_tag;
    logic [SEL_W-1:0]                    r_rr_ptr;

    logic                                w_any;
    logic                                w_hi_found;
    logic [SEL_W-1:0]                    w_hi_idx;
    logic [SEL_W-1:0]                    w_lo_idx;
    logic [SEL_W-1:0]                    w_gnt_idx;
    logic [FU_NUM-1:0]                   w_grant;
    logic [FU_NUM-1:0]                   w_ready;
    logic [SEL_W-1:0]                    w_rr_next;

    assign w_any = |r_full;

    // Lowest full slot at or above rr_ptr wins; otherwise wrap to the lowest full slot.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = FU_NUM - 1; i >= 0; i--) begin
            if (r_full[i]) begin
                w_lo_idx = SEL_W'(i);
            end
            if (r_full[i] && (i >= int'(r_rr_ptr))) begin
                w_hi_found = 1'b1;
                w_hi_idx   = SEL_W'(i);
            end
        end
    end

    assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            w_grant[i] = w_any && (w_gnt_idx == SEL_W'(i));
        end
    end

    assign w_ready   = ~r_full | w_grant;
    assign w_rr_next = (w_gnt_idx == SEL_W'(FU_NUM - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_full   <= '0;
            r_value  <= '0;
            r_tag    <= '0;
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_full   <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                // A new transfer overrides the drain of the same slot.
                if (fu_valid[i] && w_ready[i]) begin
                    r_full[i]  <= 1'b1;
                    r_value[i] <= fu_value[i];
                    r_tag[i]   <= fu_rob_tag[i];
                end else if (w_grant[i]) begin
                    r_full[i]  <= 1'b0;
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign fu_ready      = w_ready;
    assign cdb_values    = r_value;
    assign select_flag   = w_any;
    assign select_signal = w_any ? w_gnt_idx : '0;
    assign ROB_tag       = w_any ? r_tag[w_gnt_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_cdb_arbiter
// Brief   : Scenario bench for cdb_arbiter with an expected-broadcast queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;

    localparam int FU_NUM = 4;

    logic                                clock = 1'b0;
    logic                                reset_n;
    logic                                flush;
    logic [FU_NUM-1:0]                   fu_valid;
    logic [FU_NUM-1:0][`XLEN-1:0]        fu_value;
    logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] fu_rob_tag;
    logic [FU_NUM-1:0]                   fu_ready;
    logic [FU_NUM-1:0][`XLEN-1:0]        cdb_values;
    logic                                select_flag;
    logic [1:0]                          select_signal;
    logic [`ROB_TAG_LEN-1:0]             ROB_tag;

    typedef struct {
        int                      slot;
        logic [`ROB_TAG_LEN-1:0] tag;
        logic [`XLEN-1:0]        val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    cdb_arbiter #(.FU_NUM(FU_NUM)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_value     (fu_value),
        .fu_rob_tag   (fu_rob_tag),
        .fu_ready     (fu_ready),
        .cdb_values   (cdb_values),
        .select_flag  (select_flag),
        .select_signal(select_signal),
        .ROB_tag      (ROB_tag)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int s, input logic [`ROB_TAG_LEN-1:0] t, input logic [`XLEN-1:0] v);
        fu_valid[s]   = 1'b1;
        fu_rob_tag[s] = t;
        fu_value[s]   = v;
    endtask

    task automatic expect_bcast(input int s, input logic [`ROB_TAG_LEN-1:0] t, input logic [`XLEN-1:0] v);
        exp_t x;
        x.slot = s;
        x.tag  = t;
        x.val  = v;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        flush    = 1'b0;
        fu_valid = '1;
        for (int i = 0; i < FU_NUM; i++) begin
            fu_value[i]   = 32'hA000_0000 + i;
            fu_rob_tag[i] = 6'(i + 1);
        end
        tick();
        tick();
        n_checks++;
        if (select_flag !== 1'b0 || fu_ready !== 4'b1111 || ROB_tag !== '0 || select_signal !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: flag=%b ready=%b tag=%0d sel=%0d, want 0 1111 0 0",
                     select_flag, fu_ready, ROB_tag, select_signal);
        end
        n_checks++;
        if (cdb_values !== '0) begin
            n_fail++;
            $display("FAIL reset_values: cdb_values=%h, want 0", cdb_values);
        end
        fu_valid = '0;
        reset_n  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (select_flag !== 1'b0 || cdb_values !== '0 || fu_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL post_reset_idle: flag=%b vals=%h ready=%b, want 0 0 1111",
                     select_flag, cdb_values, fu_ready);
        end
    endtask

    task automatic test_single();
        drive(2, 6'd5, 32'hDEAD_BEEF);
        expect_bcast(2, 6'd5, 32'hDEAD_BEEF);
        tick();
        fu_valid = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag || cdb_values[e.slot] !== e.val) begin
            n_fail++;
            $display("FAIL single_bcast: flag=%b sel=%0d tag=%0d val=%h, want 1 %0d %0d %h",
                     select_flag, select_signal, ROB_tag, cdb_values[e.slot], e.slot, e.tag, e.val);
        end
        tick();
        n_checks++;
        if (select_flag !== 1'b0 || ROB_tag !== '0 || select_signal !== 2'd0) begin
            n_fail++;
            $display("FAIL single_idle: flag=%b tag=%0d sel=%0d, want 0 0 0", select_flag, ROB_tag, select_signal);
        end
        // rr_ptr should now be 3: slot 3 must beat slot 0.
        drive(0, 6'd10, 32'h0000_0010);
        drive(3, 6'd11, 32'h0000_0011);
        expect_bcast(3, 6'd11, 32'h0000_0011);
        expect_bcast(0, 6'd10, 32'h0000_0010);
        tick();
        fu_valid = '0;
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag || cdb_values[e.slot] !== e.val) begin
                n_fail++;
                $display("FAIL rr_after_single[%0d]: flag=%b sel=%0d tag=%0d, want 1 %0d %0d",
                         c, select_flag, select_signal, ROB_tag, e.slot, e.tag);
            end
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < FU_NUM; i++) begin
            drive(i, 6'(i + 1), 32'h1111_0000 + i);
            expect_bcast(i, 6'(i + 1), 32'h1111_0000 + i);
        end
        tick();
        fu_valid = '0;
        for (int c = 0; c < FU_NUM; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag || cdb_values[e.slot] !== e.val) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: flag=%b sel=%0d tag=%0d val=%h, want 1 %0d %0d %h",
                         c, select_flag, select_signal, ROB_tag, cdb_values[e.slot], e.slot, e.tag, e.val);
            end
            tick();
        end
        n_checks++;
        if (select_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL round_robin_drop: flag=%b, want 0", select_flag);
        end
    endtask

    task automatic test_back_pressure();
        drive(0, 6'd20, 32'h0000_0020);
        drive(1, 6'd21, 32'h0000_0021);
        tick();
        fu_valid = '0;
        drive(1, 6'd7, 32'h0000_0007);
        expect_bcast(0, 6'd20, 32'h0000_0020);
        expect_bcast(1, 6'd21, 32'h0000_0021);
        expect_bcast(1, 6'd7, 32'h0000_0007);
        n_checks++;
        if (fu_ready !== 4'b1101) begin
            n_fail++;
            $display("FAIL bp_ready_low: fu_ready=%b, want 1101", fu_ready);
        end
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag) begin
                n_fail++;
                $display("FAIL bp_bcast[%0d]: flag=%b sel=%0d tag=%0d, want 1 %0d %0d",
                         c, select_flag, select_signal, ROB_tag, e.slot, e.tag);
            end
            if (c == 1) begin
                n_checks++;
                if (fu_ready[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_ready_high: fu_ready[1]=%b, want 1", fu_ready[1]);
                end
            end
            tick();
        end
        fu_valid = '0;
        for (int c = 0; c < FU_NUM && exp_q.size() > 0; c++) begin
            if (select_flag === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (select_signal !== e.slot[1:0] || ROB_tag !== e.tag || cdb_values[e.slot] !== e.val) begin
                    n_fail++;
                    $display("FAIL bp_captured: sel=%0d tag=%0d val=%h, want %0d %0d %h",
                             select_signal, ROB_tag, cdb_values[e.slot], e.slot, e.tag, e.val);
                end
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0 || select_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_timeout: pending=%0d flag=%b, want 0 0", exp_q.size(), select_flag);
            exp_q.delete();
        end
    endtask

    task automatic test_drain_refill();
        drive(3, 6'd8, 32'h0000_0008);
        tick();
        fu_valid = '0;
        drive(3, 6'd9, 32'h0000_0009);
        expect_bcast(3, 6'd8, 32'h0000_0008);
        expect_bcast(3, 6'd9, 32'h0000_0009);
        n_checks++;
        if (fu_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_ready: fu_ready[3]=%b, want 1", fu_ready[3]);
        end
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag || cdb_values[e.slot] !== e.val) begin
                n_fail++;
                $display("FAIL refill_bcast[%0d]: flag=%b sel=%0d tag=%0d val=%h, want 1 %0d %0d %h",
                         c, select_flag, select_signal, ROB_tag, cdb_values[e.slot], e.slot, e.tag, e.val);
            end
            tick();
            fu_valid = '0;
        end
        n_checks++;
        if (select_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_drop: flag=%b, want 0", select_flag);
        end
    endtask

    task automatic test_flush();
        // rr_ptr wrapped to 0 above, so slot 0 is granted in the flush cycle.
        drive(0, 6'd30, 32'h0000_0030);
        drive(2, 6'd32, 32'h0000_0032);
        drive(3, 6'd33, 32'h0000_0033);
        tick();
        fu_valid = '0;
        flush    = 1'b1;
        drive(1, 6'd31, 32'h0000_0031);
        n_checks++;
        if (select_flag !== 1'b1 || select_signal !== 2'd0 || ROB_tag !== 6'd30) begin
            n_fail++;
            $display("FAIL flush_cycle_bcast: flag=%b sel=%0d tag=%0d, want 1 0 30", select_flag, select_signal, ROB_tag);
        end
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        n_checks++;
        if (select_flag !== 1'b0 || fu_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL flush_empty: flag=%b ready=%b, want 0 1111", select_flag, fu_ready);
        end
        drive(0, 6'd40, 32'h0000_0040);
        drive(3, 6'd43, 32'h0000_0043);
        expect_bcast(0, 6'd40, 32'h0000_0040);
        expect_bcast(3, 6'd43, 32'h0000_0043);
        tick();
        fu_valid = '0;
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select_flag !== 1'b1 || select_signal !== e.slot[1:0] || ROB_tag !== e.tag) begin
                n_fail++;
                $display("FAIL flush_rr_reset[%0d]: flag=%b sel=%0d tag=%0d, want 1 %0d %0d",
                         c, select_flag, select_signal, ROB_tag, e.slot, e.tag);
            end
            tick();
        end
        n_checks++;
        if (select_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_final_idle: flag=%b, want 0", select_flag);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        fu_valid   = '0;
        fu_value   = '0;
        fu_rob_tag = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_drain_refill();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits between the functional units and common_data_bus. It buffers one completed result per FU and picks one result per cycle with a round-robin grant.
- Drives the bus mux inputs: in_values array, select_flag, select_signal and ROB_tag.
- Applies back-pressure to FUs whose result has not yet won the bus.
- Flushes all pending results on a branch-mispredict squash.

Parameters:
- FU_NUM, 4, number of functional units; must be >= 2. Need not be a power of two.
- SEL_W, $clog2(FU_NUM), width of select_signal. Derived; do not override.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  squash: discard all buffered results.
- fu_valid  in  [FU_NUM-1:0]  FU i presents a completed result.
- fu_value  in  [FU_NUM-1:0][`XLEN-1:0]  result data per FU.
- fu_rob_tag  in  [FU_NUM-1:0][`ROB_TAG_LEN-1:0]  ROB tag per FU.
- fu_ready  out  [FU_NUM-1:0]  slot i can accept a result this cycle.
- cdb_values  out  [FU_NUM-1:0][`XLEN-1:0]  slot data, to common_data_bus in_values.
- select_flag  out  1  a result is broadcast this cycle.
- select_signal  out  SEL_W  index of the granted slot.
- ROB_tag  out  `ROB_TAG_LEN  ROB tag of the granted slot.

Behaviour:
- Reset and clocking:
  - One clock domain.
  - Reset is synchronous and active-low: when reset_n=0 at a rising edge, all slots go empty, rr_ptr goes to 0, and stored value/tag registers go to 0.
  - Outputs after reset: select_flag=0, select_signal=0, ROB_tag=0, cdb_values all 0, fu_ready all 1.
- State:
  - Per FU slot: full bit, value register, tag register.
  - rr_ptr, SEL_W bits, range 0..FU_NUM-1.
- Handshake:
  - A transfer from FU i occurs on an edge where fu_valid[i] && fu_ready[i]. At that edge the slot captures fu_value[i] and fu_rob_tag[i] and sets full.
  - fu_valid with fu_ready=0 is ignored. The FU must hold its result until it sees ready.
  - fu_ready[i] = !full[i] || grant[i]. A granted slot accepts a new result in the same cycle it is drained.
- Grant (combinational from slot state only; there is no same-cycle bypass from fu_*):
  - Scan slots rr_ptr, rr_ptr+1, ... with wrap modulo FU_NUM.
  - The first full slot is granted; at most one grant per cycle.
- Outputs (combinational from registers):
  - select_flag = |full.
  - When select_flag=1: select_signal = granted index and ROB_tag = that slot's tag.
  - When select_flag=0: select_signal = 0 and ROB_tag = 0.
  - cdb_values[i] = slot i value register regardless of full. An empty slot holds its last value, or 0 after reset.
- On an edge with a grant to slot g:
  - full[g] clears, unless a new transfer into g happens on the same edge; then full stays 1 with the new data.
  - rr_ptr <= (g == FU_NUM-1) ? 0 : g+1.
  - With no grant, rr_ptr holds.
- Latency:
  - Result accepted at edge N appears on the bus during cycle N+1, provided it wins arbitration.
  - Worst-case wait with all slots full is FU_NUM cycles.
- Flush (reset_n=1, flush=1 at an edge):
  - All full bits clear and rr_ptr goes to 0. Value and tag registers may hold.
  - Transfers on that edge are dropped, even though fu_ready may be 1.
  - The broadcast in the flush cycle itself still happens, because outputs are combinational from pre-edge state.
- Priority at an edge: reset > flush > transfer/grant.
- Starvation-free: each full slot is granted within FU_NUM cycles.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with fu_valid=4'b1111 -> select_flag=0, fu_ready=4'b1111, no slot fills; after release, outputs stay 0 until the first transfer.
- Single result: fu_valid[2]=1, value=32'hDEAD_BEEF, tag=5 for one cycle -> next cycle select_flag=1, select_signal=2, ROB_tag=5, cdb_values[2]=32'hDEAD_BEEF; the following cycle select_flag=0 and rr_ptr=3.
- Round-robin, all four FUs valid at the same edge with tags 1,2,3,4 and rr_ptr=0 -> grants 0,1,2,3 on four consecutive cycles with ROB_tag 1,2,3,4; select_flag drops on the fifth cycle.
- Back-pressure: slot 1 full and not granted (slot 0 also full, rr_ptr=0), FU1 presents tag 7 -> fu_ready[1]=0, tag 7 not captured. Next cycle slot 1 is granted with its old tag, fu_ready[1]=1 and tag 7 is captured. Tag 7 is broadcast once slot 1 next wins the grant after the wrap.
- Drain-and-refill: FU_NUM=4, only slot 3 full and granted; FU3 presents tag 9 the same cycle -> full[3] stays 1, next cycle ROB_tag=9, rr_ptr wraps to 0.
- Flush: slots 0, 2 and 3 full; assert flush with fu_valid[1]=1 -> next cycle select_flag=0, fu_ready=4'b1111, slot 1 not filled, rr_ptr=0.
